// File: rtl/afifo_rd_stream_pkg.sv
// Shared defaults and occupancy encoding for the async-FIFO read-side streamer.
package afifo_rd_stream_pkg;

  localparam int unsigned DSIZE_DEF     = 8;
  localparam int unsigned FRAME_LEN_DEF = 16;
  localparam int unsigned CW_DEF        = 16;

  // Output buffer occupancy; value 3 never occurs.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready buffer. Head slot drives the output directly from flops;
// the tail slot only holds a word while the head is stalled.
module stream_skid2
  import afifo_rd_stream_pkg::*;
#(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             pop_o,
  output logic [1:0]       occ_o
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;

  assign valid_o = (occ_q != OCC_EMPTY);
  assign data_o  = head_q;
  assign pop_o   = valid_o & ready_i;
  assign occ_o   = occ_q;

  // Next-state for slots and occupancy; clear drops everything buffered.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clear_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push_i) begin
            head_d = data_i;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({push_i, pop_o})
            2'b11: head_d = data_i;
            2'b10: begin
              tail_d = data_i;
              occ_d  = OCC_FULL;
            end
            2'b01: occ_d = OCC_EMPTY;
            default: ;
          endcase
        end
        OCC_FULL: begin
          // Push is only allowed here together with a pop.
          if (pop_o) begin
            head_d = tail_q;
            if (push_i) begin
              tail_d = data_i;
            end else begin
              occ_d = OCC_ONE;
            end
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= OCC_EMPTY;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/afifo_rd_stream.sv
// Read-domain consumer: pulls words from the FIFO show-ahead port into a
// two-entry buffer and presents them as a framed valid/ready stream.
module afifo_rd_stream
  import afifo_rd_stream_pkg::*;
#(
  parameter int unsigned DSIZE     = DSIZE_DEF,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned CW        = CW_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CW-1:0]    rd_count,
  input  logic             flush
);

  logic [1:0]      occ;
  logic            pop;
  logic            word_last;
  logic [DSIZE:0]  head;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // A word may be taken while a slot is free or one leaves this cycle; reset
  // gates it so rinc reads 0 for the whole reset interval.
  assign rinc = rrst_n & ~rempty & ~flush & ((occ != OCC_FULL) | pop);

  assign word_last = (fcnt_q == CW'(FRAME_LEN - 1));

  stream_skid2 #(
    .Width (DSIZE + 1)
  ) u_skid (
    .clk_i   (rclk),
    .rst_ni  (rrst_n),
    .clear_i (flush),
    .push_i  (rinc),
    .data_i  ({word_last, rdata}),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (head),
    .pop_o   (pop),
    .occ_o   (occ)
  );

  assign m_last   = head[DSIZE];
  assign m_data   = head[DSIZE-1:0];
  assign rd_count = cnt_q;

  // Frame position of the next pushed word, and accepted-word counter.
  always_comb begin
    fcnt_d = fcnt_q;
    if (flush) begin
      fcnt_d = '0;
    end else if (rinc) begin
      fcnt_d = word_last ? '0 : fcnt_q + CW'(1);
    end
    cnt_d = cnt_q + CW'(pop);
  end

  // Counter registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      fcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
